// File: rtl/ed25519_out_serializer.sv
// Streams each 512-bit {x, y} result as eight 64-bit big-endian beats, holding an active and a pending slot.
// Optional FINAL_REDUCE_EN: one conditional subtraction of p = 2^255-19 per coordinate on capture.
module ed25519_out_serializer #(
  parameter  int DATA_W = 64,
  parameter  int PATN_W = 256,
  localparam int BEATS  = 2 * PATN_W / DATA_W
) (
  input  logic              i_clk,
  input  logic              i_rst,
  input  logic              i_res_valid,
  output logic              o_res_ready,
  input  logic [PATN_W-1:0] i_res_x,
  input  logic [PATN_W-1:0] i_res_y,
  output logic              o_out_valid,
  input  logic              i_out_ready,
  output logic [DATA_W-1:0] o_out_data,
  output logic              o_busy
);

  localparam int RES_W = 2 * PATN_W;
  localparam int CNT_W = $clog2(BEATS);

  typedef enum logic {IDLE, SEND} state_t;

  state_t             r_state;
  logic [RES_W-1:0]   r_act;
  logic [RES_W-1:0]   r_pend;
  logic               r_pend_full;
  logic [CNT_W-1:0]   r_cnt;

  logic               w_xfer;
  logic               w_last;
  logic               w_acc;
  logic               w_act_free;
  logic [RES_W-1:0]   w_new;
  logic [RES_W-1:0]   w_shift;

  function automatic logic [PATN_W-1:0] f_reduce(input logic [PATN_W-1:0] v);
`ifdef FINAL_REDUCE_EN
    logic [PATN_W-1:0] p;
    p = {1'b0, {(PATN_W-1){1'b1}}} - PATN_W'(18);
    return (v >= p) ? v - p : v;
`else
    return v;
`endif
  endfunction

  assign w_xfer     = (r_state == SEND) && i_out_ready;
  assign w_last     = w_xfer && (r_cnt == CNT_W'(BEATS - 1));
  assign w_acc      = i_res_valid && !r_pend_full;
  assign w_act_free = (r_state == IDLE) || w_last;
  assign w_new      = {f_reduce(i_res_x), f_reduce(i_res_y)};
  // Active slot is a shift register so the current beat is always its top word.
  assign w_shift    = {r_act[RES_W-DATA_W-1:0], {DATA_W{1'b0}}};

  always_ff @(posedge i_clk) begin
    if (i_rst) begin
      r_state     <= IDLE;
      r_act       <= '0;
      r_pend      <= '0;
      r_pend_full <= 1'b0;
      r_cnt       <= '0;
    end else if (w_act_free) begin
      if (r_pend_full) begin
        r_act   <= r_pend;
        r_cnt   <= '0;
        r_state <= SEND;
        if (w_acc) r_pend <= w_new;
        else       r_pend_full <= 1'b0;
      end else if (w_acc) begin
        r_act   <= w_new;
        r_cnt   <= '0;
        r_state <= SEND;
      end else begin
        r_state <= IDLE;
        if (w_xfer) r_act <= w_shift;
      end
    end else begin
      if (w_xfer) begin
        r_act <= w_shift;
        r_cnt <= r_cnt + CNT_W'(1);
      end
      if (w_acc) begin
        r_pend      <= w_new;
        r_pend_full <= 1'b1;
      end
    end
  end

  assign o_out_valid = (r_state == SEND);
  assign o_out_data  = r_act[RES_W-1 -: DATA_W];
  assign o_res_ready = !r_pend_full;
  assign o_busy      = (r_state == SEND) || r_pend_full;

endmodule

// File: tb/tb_ed25519_out_serializer.sv
// Randomised and directed bench for ed25519_out_serializer against a beat-queue reference model.
module tb_ed25519_out_serializer;

  localparam logic [255:0] P  = 256'h7fffffffffffffffffffffffffffffffffffffffffffffffffffffffffffffed;
  localparam logic [255:0] X1 = 256'h0123456789abcdef_1122334455667788_99aabbccddeeff00_0f1e2d3c4b5a6978;
  localparam logic [255:0] Y1 = 256'hfedcba9876543210_a5a5a5a5a5a5a5a5_5a5a5a5a5a5a5a5a_0011223344556677;

  logic         clk = 1'b0;
  logic         rst;
  logic         res_valid;
  logic         res_ready;
  logic [255:0] rx;
  logic [255:0] ry;
  logic         out_valid;
  logic         out_ready;
  logic [63:0]  out_data;
  logic         busy;

  int unsigned vectors = 0;
  int unsigned miscompares = 0;
  logic [63:0] mq[$];
  logic [63:0] log_q[$];

  always #5 clk = ~clk;

  ed25519_out_serializer #(.DATA_W(64), .PATN_W(256)) dut (
    .i_clk(clk), .i_rst(rst),
    .i_res_valid(res_valid), .o_res_ready(res_ready),
    .i_res_x(rx), .i_res_y(ry),
    .o_out_valid(out_valid), .i_out_ready(out_ready),
    .o_out_data(out_data), .o_busy(busy)
  );

  function automatic logic [255:0] red(input logic [255:0] v);
`ifdef FINAL_REDUCE_EN
    if (v >= P) return v - P;
`endif
    return v;
  endfunction

  // Results held = results with beats still outstanding; pending is full when two are held.
  function automatic int held();
    return (mq.size() + 7) / 8;
  endfunction

  function automatic logic [255:0] rnd();
    logic [255:0] v;
    for (int i = 0; i < 8; i++) v[32*i +: 32] = $urandom;
    case ($urandom % 10)
      0: v = P + 256'd5;
      1: v = P - 256'd1;
      2: v = P;
      3: v = '1;
      default: ;
    endcase
    return v;
  endfunction

  task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
    vectors++;
    if (act !== exp) begin
      miscompares++;
      $display("FAIL %s: got %h expected %h at %0t", name, act, exp, $time);
    end
  endtask

  always @(posedge clk) begin
    logic [511:0] r;
    bit xfer;
    bit acc;
    if (rst) mq.delete();
    else begin
      xfer = (mq.size() > 0) && out_ready;
      acc  = res_valid && (held() < 2);
      if (xfer) void'(mq.pop_front());
      if (acc) begin
        r = {red(rx), red(ry)};
        for (int k = 0; k < 8; k++) mq.push_back(r[511-64*k -: 64]);
      end
    end
  end

  always @(negedge clk) begin
    chk("valid", out_valid, mq.size() > 0);
    chk("ready", res_ready, held() < 2);
    chk("busy", busy, mq.size() > 0);
    if (mq.size() > 0) chk("data", out_data, mq[0]);
    if (out_valid && out_ready) log_q.push_back(out_data);
  end

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic send(input logic [255:0] x, input logic [255:0] y);
    res_valid = 1'b1;
    rx = x;
    ry = y;
    for (int i = 0; i < 300; i++) begin
      @(negedge clk);
      if (held() < 2) begin
        tick();
        res_valid = 1'b0;
        return;
      end
    end
    chk("accept_timeout", 64'd0, 64'd1);
    res_valid = 1'b0;
  endtask

  task automatic drain();
    for (int i = 0; i < 600; i++) begin
      if (mq.size() == 0 && !out_valid) return;
      tick();
    end
    chk("drain_timeout", 64'd0, 64'd1);
  endtask

  initial begin
    #3_000_000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  initial begin
    logic [511:0] w;
    rst = 1'b1; res_valid = 1'b0; out_ready = 1'b0; rx = '0; ry = '0;
    tick(); tick();
    rst = 1'b0;
    @(negedge clk);
    chk("rst_data", out_data, 64'd0);
    chk("rst_ready", res_ready, 64'd1);
    tick();

    // single result, ready high
    out_ready = 1'b1; log_q.delete();
    send(X1, Y1);
    @(negedge clk);
    chk("t1_latency", out_valid, 64'd1);
    drain();
    chk("t1_count", log_q.size(), 64'd8);
    chk("t1_b0", log_q[0], 64'h0123456789abcdef);
    chk("t1_b3", log_q[3], 64'h0f1e2d3c4b5a6978);
    chk("t1_b4", log_q[4], 64'hfedcba9876543210);
    chk("t1_b7", log_q[7], 64'h0011223344556677);

    // stalled output
    out_ready = 1'b0; log_q.delete();
    send(Y1, X1);
    for (int c = 0; c < 60 && mq.size() > 0; c++) begin
      out_ready = (c % 3 == 0);
      tick();
    end
    out_ready = 1'b1;
    drain();
    chk("t2_count", log_q.size(), 64'd8);
    w = {Y1, X1};
    for (int k = 0; k < 8; k++) chk("t2_beat", log_q[k], w[511-64*k -: 64]);

    // three results against a stalled host
    out_ready = 1'b0; log_q.delete();
    res_valid = 1'b1; rx = X1; ry = Y1; tick();
    rx = Y1; ry = X1; tick();
    rx = X1; ry = X1;
    repeat (20) tick();
    @(negedge clk);
    chk("t3_ready_low", res_ready, 64'd0);
    tick();
    out_ready = 1'b1;
    for (int i = 0; i < 100; i++) begin
      @(negedge clk);
      if (held() < 2) break;
    end
    tick();
    res_valid = 1'b0;
    drain();
    chk("t3_count", log_q.size(), 64'd24);
    chk("t3_r0", log_q[0], 64'h0123456789abcdef);
    chk("t3_r1", log_q[8], 64'hfedcba9876543210);
    chk("t3_r2", log_q[20], 64'h0123456789abcdef);

    // acceptance on the last-beat edge
    out_ready = 1'b1; log_q.delete();
    send(Y1, Y1);
    repeat (7) tick();
    res_valid = 1'b1; rx = X1; ry = Y1;
    tick();
    res_valid = 1'b0;
    @(negedge clk);
    chk("t4_no_bubble", out_valid, 64'd1);
    chk("t4_b0", out_data, 64'h0123456789abcdef);
    drain();
    chk("t4_count", log_q.size(), 64'd16);

    // reset mid-stream
    out_ready = 1'b1; log_q.delete();
    send(Y1, X1);
    for (int i = 0; i < 50 && log_q.size() < 4; i++) tick();
    out_ready = 1'b0; rst = 1'b1;
    tick();
    rst = 1'b0;
    @(negedge clk);
    chk("t5_valid", out_valid, 64'd0);
    chk("t5_ready", res_ready, 64'd1);
    chk("t5_busy", busy, 64'd0);
    chk("t5_data", out_data, 64'd0);
    tick();
    out_ready = 1'b1; log_q.delete();
    send(X1, Y1);
    drain();
    chk("t5_fresh_b0", log_q[0], 64'h0123456789abcdef);
    chk("t5_fresh_cnt", log_q.size(), 64'd8);

    // values around p
    log_q.delete();
    send(P + 256'd5, P - 256'd1);
    drain();
`ifdef FINAL_REDUCE_EN
    chk("t6_x0", log_q[0], 64'h0);
    chk("t6_x3", log_q[3], 64'h5);
`else
    chk("t6_x0", log_q[0], 64'h7fffffffffffffff);
    chk("t6_x3", log_q[3], 64'hfffffffffffffff2);
`endif
    chk("t6_y4", log_q[4], 64'h7fffffffffffffff);
    chk("t6_y7", log_q[7], 64'hffffffffffffffec);
    log_q.delete();
    send(P, 256'd0);
    drain();
`ifdef FINAL_REDUCE_EN
    chk("t6_p3", log_q[3], 64'h0);
`else
    chk("t6_p3", log_q[3], 64'hffffffffffffffed);
`endif

    // randomised traffic
    for (int c = 0; c < 2000; c++) begin
      out_ready = ($urandom % 4) != 0;
      res_valid = ($urandom % 3) == 0;
      rx = rnd();
      ry = rnd();
      rst = ($urandom % 400) == 0;
      tick();
    end
    rst = 1'b0; res_valid = 1'b0; out_ready = 1'b1;
    drain();

    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

endmodule
